// File: rtl/stall_mem_pkg.sv
// rtl/stall_mem_pkg.sv - shared types and width helpers for the stall memory responder
package stall_mem_pkg;

  // Responder FSM: IDLE serves hits/errors in-cycle, BUSY counts out a miss
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Operation latched for a miss in flight
  typedef enum logic [0:0] {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Word address width: byte address bits [15:1]
  localparam int WA_W = 15;

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_width(input int lines);
    return WA_W - $clog2(lines);
  endfunction

endpackage

// File: rtl/stall_mem_tag_array.sv
// rtl/stall_mem_tag_array.sv - direct-mapped one-word-per-line valid/tag/data storage
module stall_mem_tag_array #(
  parameter int LINES = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [15:0]      rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [TAG_W-1:0] w_tag,
  input  logic [15:0]      w_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [15:0]      data_q [LINES];

  // Lookup is purely combinational so a hit completes in the request cycle
  always_comb begin
    hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    rdata = data_q[lk_idx];
  end

  // A fill or write marks the line valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[w_idx] = 1'b1;
  end

  // Valid bits clear on reset; tag/data contents are don't-care until valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (we) begin
        tag_q[w_idx]  <= w_tag;
        data_q[w_idx] <= w_data;
      end
    end
  end

endmodule

// File: rtl/stall_mem_responder.sv
// rtl/stall_mem_responder.sv - cached data-memory responder with fixed miss stall; optional dump via STALL_MEM_DUMP_EN
module stall_mem_responder
  import stall_mem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LINES     = 8,
  parameter int MISS_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(LINES);
  localparam int BW    = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MISS_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WA_W-1:0]   lat_wa_q, lat_wa_d;
  logic [15:0]       lat_data_q, lat_data_d;
  op_e               lat_op_q, lat_op_d;
  logic [15:0]       mem_q [MEM_WORDS];

  logic [WA_W-1:0]   wa_in;
  logic              illegal;
  logic              arr_hit;
  logic [15:0]       arr_rdata;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_widx;
  logic [TAG_W-1:0]  arr_wtag;
  logic [15:0]       arr_wdata;
  logic              mem_we;
  logic [BW-1:0]     mem_widx;
  logic [15:0]       mem_wdata;

  assign wa_in   = Addr[15:1];
  assign illegal = (Rd | Wr) & (Addr[0] | (Rd & Wr));

  stall_mem_tag_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .lk_idx (wa_in[IDX_W-1:0]),
    .lk_tag (wa_in[WA_W-1:IDX_W]),
    .hit    (arr_hit),
    .rdata  (arr_rdata),
    .we     (arr_we),
    .w_idx  (arr_widx),
    .w_tag  (arr_wtag),
    .w_data (arr_wdata)
  );

  // Request decode, response outputs and array write strobes; reset forces everything quiet
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_wa_d   = lat_wa_q;
    lat_data_d = lat_data_q;
    lat_op_d   = lat_op_q;
    DataOut    = 16'h0000;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    arr_we     = 1'b0;
    arr_widx   = wa_in[IDX_W-1:0];
    arr_wtag   = wa_in[WA_W-1:IDX_W];
    arr_wdata  = DataIn;
    mem_we     = 1'b0;
    mem_widx   = wa_in[BW-1:0];
    mem_wdata  = DataIn;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (Rd | Wr) begin
            if (illegal) begin
              Done = 1'b1;
              err  = 1'b1;
            end else if (arr_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              if (Rd) begin
                DataOut = arr_rdata;
              end else begin
                arr_we = 1'b1;
                mem_we = 1'b1;
              end
            end else begin
              Stall      = 1'b1;
              lat_wa_d   = wa_in;
              lat_data_d = DataIn;
              lat_op_d   = Rd ? OP_RD : OP_WR;
              cnt_d      = CNT_W'(MISS_LAT - 1);
              state_d    = BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            Stall = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            Done     = 1'b1;
            state_d  = IDLE;
            arr_we   = 1'b1;
            arr_widx = lat_wa_q[IDX_W-1:0];
            arr_wtag = lat_wa_q[WA_W-1:IDX_W];
            if (lat_op_q == OP_RD) begin
              DataOut   = mem_q[lat_wa_q[BW-1:0]];
              arr_wdata = mem_q[lat_wa_q[BW-1:0]];
            end else begin
              arr_wdata = lat_data_q;
              mem_we    = 1'b1;
              mem_widx  = lat_wa_q[BW-1:0];
              mem_wdata = lat_data_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and miss-latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_wa_q   <= '0;
      lat_data_q <= '0;
      lat_op_q   <= OP_RD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_wa_q   <= lat_wa_d;
      lat_data_q <= lat_data_d;
      lat_op_q   <= lat_op_d;
    end
  end

  // Backing store: zeroed on reset, written through on every completed write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 16'h0000;
    end else if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

`ifdef STALL_MEM_DUMP_EN
  logic dump_done_q, dump_done_d;

  // One dump per createdump assertion; waiting for IDLE defers a dump requested mid-miss
  always_comb begin
    dump_done_d = dump_done_q;
    if (!createdump) dump_done_d = 1'b0;
    else if (state_q == IDLE) dump_done_d = 1'b1;
  end

  // Dump-armed flag
  always_ff @(posedge clk) begin
    if (rst) dump_done_q <= 1'b0;
    else     dump_done_q <= dump_done_d;
  end

  // Emit the backing store image on the first eligible IDLE cycle
  always_ff @(posedge clk) begin
    if (!rst && createdump && (state_q == IDLE) && !dump_done_q) begin
      for (int i = 0; i < MEM_WORDS; i++)
        $display("DUMP %0h %04h", i, mem_q[i]);
    end
  end
`else
  logic unused_createdump;
  assign unused_createdump = createdump;
`endif

endmodule

// File: tb/tb_stall_mem_responder.sv
// tb/tb_stall_mem_responder.sv - scoreboard bench with a reference memory/cache model
module tb_stall_mem_responder;

  localparam int MEM_WORDS = 256;
  localparam int LINES     = 8;
  localparam int MISS_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] Addr = 16'h0;
  logic [15:0] DataIn = 16'h0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic        createdump = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;

  always #5 clk = ~clk;

  stall_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LINES     (LINES),
    .MISS_LAT  (MISS_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .createdump (createdump),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err)
  );

  typedef struct {
    logic        is_err;
    logic        is_hit;
    logic        is_rd;
    logic [15:0] data;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // Reference model: backing words plus per-line valid/tag/data
  logic [15:0] m_mem [MEM_WORDS];
  logic        m_valid [LINES];
  int          m_tag [LINES];
  logic [15:0] m_cdata [LINES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 16'h0;
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_cdata[i] = 16'h0;
    end
  endtask

  function automatic exp_t predict(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int wa, idx, tag, bi;
    wa  = int'(a[15:1]);
    idx = wa % LINES;
    tag = wa / LINES;
    bi  = wa % MEM_WORDS;
    e.is_err = 1'b0; e.is_hit = 1'b0; e.is_rd = rd; e.data = 16'h0; e.stalls = 0;
    if (a[0] || (rd && wr)) begin
      e.is_err = 1'b1;
    end else if (m_valid[idx] && m_tag[idx] == tag) begin
      e.is_hit = 1'b1;
      if (rd) e.data = m_cdata[idx];
      else begin
        m_mem[bi] = d;
        m_cdata[idx] = d;
      end
    end else begin
      e.stalls = MISS_LAT;
      if (rd) e.data = m_mem[bi];
      else m_mem[bi] = d;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_cdata[idx] = m_mem[bi];
    end
    return e;
  endfunction

  // Monitor: pops an expectation whenever the DUT completes a request
  int stall_cnt = 0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (Stall) begin
        if (q.size() == 0) chk("unexpected_stall", 1, 0);
        chk("stall_has_no_done", {31'b0, Done}, 0);
        chk("stall_dataout_zero", {16'b0, DataOut}, 0);
        stall_cnt++;
      end else if (Done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err", {31'b0, err}, {31'b0, e.is_err});
          chk("cachehit", {31'b0, CacheHit}, {31'b0, e.is_hit});
          chk("stall_cycles", stall_cnt, e.stalls);
          chk("dataout", {16'b0, DataOut}, {16'b0, (e.is_rd && !e.is_err) ? e.data : 16'h0});
        end
        stall_cnt = 0;
      end else begin
        chk("idle_outputs_zero", {15'b0, err, CacheHit, DataOut}, 0);
      end
    end
  end

  // Driver: present a request (at posedge+1) and hold it until Done
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    q.push_back(predict(rd, wr, a, d));
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (Done) break;
      n++;
    end
    if (n >= 20) begin
      chk("done_timeout", 1, 0);
      q.delete();
    end
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic idle_cycle();
    Rd = 1'b0; Wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    stall_cnt = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset cycle with a request present: every output stays 0
    Rd = 1'b1; Addr = 16'h0010;
    @(negedge clk);
    chk("reset_outputs", {13'b0, Done, Stall, CacheHit, err, DataOut}, 0);
    @(posedge clk); #1;
    Rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Cold miss, re-hit, write hit, illegal requests, conflict eviction
    issue(1, 0, 16'h0010, 16'h0);
    issue(1, 0, 16'h0010, 16'h0);
    issue(0, 1, 16'h0010, 16'hBEEF);
    issue(1, 0, 16'h0010, 16'h0);
    issue(1, 0, 16'h0011, 16'h0);
    issue(1, 1, 16'h0010, 16'h0);
    issue(1, 0, 16'h0010, 16'h0);
    issue(1, 0, 16'h0020, 16'h0);
    issue(1, 0, 16'h0010, 16'h0);

    // Write miss from reset, then read hit
    do_reset();
    issue(0, 1, 16'h0100, 16'h1234);
    issue(1, 0, 16'h0100, 16'h0);

    // Reset in cycle 2 of a write miss aborts it
    do_reset();
    mon_en = 1'b0;
    Wr = 1'b1; Addr = 16'h0040; DataIn = 16'hAAAA;
    @(negedge clk);
    chk("abort_stall_c0", {31'b0, Stall}, 1);
    @(negedge clk);
    chk("abort_stall_c1", {31'b0, Stall}, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_quiet", {31'b0, Done | Stall}, 0);
    @(posedge clk); #1;
    rst = 1'b0; Wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'b0, Done | Stall}, 0);
    end
    @(posedge clk); #1;
    model_reset();
    stall_cnt = 0;
    mon_en = 1'b1;
    issue(1, 0, 16'h0040, 16'h0);

    // Randomized traffic: small address pool with backing-index aliases
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [14:0] wa;
      logic [15:0] a;
      logic rd, wr;
      r  = int'($urandom_range(0, 99));
      wa = 15'($urandom_range(0, 23));
      if ($urandom_range(0, 3) == 0) wa = wa + 15'h100;
      a  = {wa, 1'b0};
      if (r < 8) begin
        idle_cycle();
      end else begin
        if (r < 14) a[0] = 1'b1;
        if (r >= 14 && r < 19) begin
          rd = 1'b1; wr = 1'b1;
        end else begin
          rd = 1'($urandom_range(0, 1)); wr = !rd;
        end
        issue(rd, wr, a, 16'($urandom));
      end
    end

    idle_cycle();
    idle_cycle();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
